// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
// Holds the channel state encoding and an index-width helper.
package mem_arb_pkg;

  localparam int ADDR_BITS_D = 8;
  localparam int DATA_BITS_D = 8;
  localparam int NUM_CONSUMERS_D = 4;
  localparam int NUM_CHANNELS_D = 1;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    READ_RELAY,
    WRITE_RELAY
  } arb_state_t;

  function automatic int idx_bits(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// LSU-side and memory-side handshake bundles for mem_arbiter.
// lsu: per-consumer read/write valid/ready; mem: per-channel ports.
interface mem_arb_lsu_if #(
  parameter int N  = 4,
  parameter int AW = 8,
  parameter int DW = 8
);
  logic [N-1:0]         consumer_read_valid;
  logic [N-1:0][AW-1:0] consumer_read_address;
  logic [N-1:0]         consumer_read_ready;
  logic [N-1:0][DW-1:0] consumer_read_data;
  logic [N-1:0]         consumer_write_valid;
  logic [N-1:0][AW-1:0] consumer_write_address;
  logic [N-1:0][DW-1:0] consumer_write_data;
  logic [N-1:0]         consumer_write_ready;

  modport master (
    output consumer_read_valid,
    output consumer_read_address,
    input  consumer_read_ready,
    input  consumer_read_data,
    output consumer_write_valid,
    output consumer_write_address,
    output consumer_write_data,
    input  consumer_write_ready
  );

  modport slave (
    input  consumer_read_valid,
    input  consumer_read_address,
    output consumer_read_ready,
    output consumer_read_data,
    input  consumer_write_valid,
    input  consumer_write_address,
    input  consumer_write_data,
    output consumer_write_ready
  );
endinterface

interface mem_arb_mem_if #(
  parameter int M  = 1,
  parameter int AW = 8,
  parameter int DW = 8
);
  logic [M-1:0]         mem_read_valid;
  logic [M-1:0][AW-1:0] mem_read_address;
  logic [M-1:0]         mem_read_ready;
  logic [M-1:0][DW-1:0] mem_read_data;
  logic [M-1:0]         mem_write_valid;
  logic [M-1:0][AW-1:0] mem_write_address;
  logic [M-1:0][DW-1:0] mem_write_data;
  logic [M-1:0]         mem_write_ready;

  modport master (
    output mem_read_valid,
    output mem_read_address,
    input  mem_read_ready,
    input  mem_read_data,
    output mem_write_valid,
    output mem_write_address,
    output mem_write_data,
    input  mem_write_ready
  );

  modport slave (
    input  mem_read_valid,
    input  mem_read_address,
    output mem_read_ready,
    output mem_read_data,
    input  mem_write_valid,
    input  mem_write_address,
    input  mem_write_data,
    output mem_write_ready
  );
endinterface

// File: rtl/mem_arb_channel.sv
// One memory channel: pick, forward, relay, release (MEM_ARB_ROUND_ROBIN_EN).
// avail masks consumers claimed elsewhere; grant/done feed the claim map.
module mem_arb_channel
  import mem_arb_pkg::*;
#(
  parameter int NUM_CONSUMERS = NUM_CONSUMERS_D,
  parameter int ADDR_BITS     = ADDR_BITS_D,
  parameter int DATA_BITS     = DATA_BITS_D,
  localparam int N  = NUM_CONSUMERS,
  localparam int IW = idx_bits(NUM_CONSUMERS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N-1:0]                rd_req,
  input  logic [N-1:0][ADDR_BITS-1:0] rd_addr,
  input  logic [N-1:0]                wr_req,
  input  logic [N-1:0][ADDR_BITS-1:0] wr_addr,
  input  logic [N-1:0][DATA_BITS-1:0] wr_data,
  input  logic [N-1:0]                avail,
  output logic [N-1:0]                grant,
  output logic [N-1:0]                done,
  output logic                        mem_rv,
  output logic [ADDR_BITS-1:0]        mem_ra,
  input  logic                        mem_rr,
  input  logic [DATA_BITS-1:0]        mem_rd,
  output logic                        mem_wv,
  output logic [ADDR_BITS-1:0]        mem_wa,
  output logic [DATA_BITS-1:0]        mem_wd,
  input  logic                        mem_wr,
  output logic [IW-1:0]               idx,
  output logic                        rd_ready,
  output logic                        wr_ready,
  output logic [DATA_BITS-1:0]        rd_data
);

  arb_state_t    state;
  logic [N-1:0]  req;
  logic          found;
  logic [IW-1:0] pick;
  logic          rel;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] ptr;
`endif

  assign req = (rd_req | wr_req) & avail;

  always_comb begin
    int j;
    found = 1'b0;
    pick  = '0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      j = (int'(ptr) + k) % N;
`else
      j = k;
`endif
      if (!found && req[j]) begin
        found = 1'b1;
        pick  = IW'(j);
      end
    end
  end

  assign rel = (state == READ_RELAY && !rd_req[idx])
            || (state == WRITE_RELAY && !wr_req[idx]);

  always_comb begin
    grant = '0;
    done  = '0;
    if (state == IDLE && found) grant[pick] = 1'b1;
    if (rel) done[idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= '0;
      mem_rv   <= 1'b0;
      mem_ra   <= '0;
      mem_wv   <= 1'b0;
      mem_wa   <= '0;
      mem_wd   <= '0;
      rd_ready <= 1'b0;
      wr_ready <= 1'b0;
      rd_data  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr      <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: if (found) begin
          idx <= pick;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          ptr <= (int'(pick) == N - 1)
               ? '0 : pick + IW'(1);
`endif
          if (rd_req[pick]) begin
            mem_rv <= 1'b1;
            mem_ra <= rd_addr[pick];
            state  <= READ_WAIT;
          end else begin
            mem_wv <= 1'b1;
            mem_wa <= wr_addr[pick];
            mem_wd <= wr_data[pick];
            state  <= WRITE_WAIT;
          end
        end
        READ_WAIT: if (mem_rr) begin
          mem_rv   <= 1'b0;
          rd_data  <= mem_rd;
          rd_ready <= 1'b1;
          state    <= READ_RELAY;
        end
        WRITE_WAIT: if (mem_wr) begin
          mem_wv   <= 1'b0;
          wr_ready <= 1'b1;
          state    <= WRITE_RELAY;
        end
        READ_RELAY: if (rel) begin
          rd_ready <= 1'b0;
          state    <= IDLE;
        end
        WRITE_RELAY: if (rel) begin
          wr_ready <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Data-memory arbiter: NUM_CONSUMERS LSUs onto NUM_CHANNELS ports.
// Ports: clk, reset (async low), lsu (slave), mem (master); MEM_ARB_ROUND_ROBIN_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_BITS     = ADDR_BITS_D,
  parameter int DATA_BITS     = DATA_BITS_D,
  parameter int NUM_CONSUMERS = NUM_CONSUMERS_D,
  parameter int NUM_CHANNELS  = NUM_CHANNELS_D
) (
  input logic           clk,
  input logic           reset,
  mem_arb_lsu_if.slave  lsu,
  mem_arb_mem_if.master mem
);

  localparam int N  = NUM_CONSUMERS;
  localparam int M  = NUM_CHANNELS;
  localparam int IW = idx_bits(N);

  logic [N-1:0]                claim;
  logic [N-1:0]                granted;
  logic [N-1:0]                freed;
  logic [M-1:0][IW-1:0]        ch_idx;
  logic [M-1:0]                ch_rr;
  logic [M-1:0]                ch_wr;
  logic [M-1:0][DATA_BITS-1:0] ch_rd;
  logic [N-1:0]                rr;
  logic [N-1:0]                wr;
  logic [N-1:0][DATA_BITS-1:0] rd;

  // av narrows channel by channel so lower channels win a consumer.
  for (genvar c = 0; c < M; c++) begin : g_ch
    logic [N-1:0] av;
    logic [N-1:0] gnt;
    logic [N-1:0] dn;
    logic [N-1:0] dn_acc;

    if (c == 0) begin : g_first
      assign av     = ~claim;
      assign dn_acc = dn;
    end else begin : g_next
      assign av     = g_ch[c-1].av & ~g_ch[c-1].gnt;
      assign dn_acc = g_ch[c-1].dn_acc | dn;
    end

    mem_arb_channel #(
      .NUM_CONSUMERS(N),
      .ADDR_BITS(ADDR_BITS),
      .DATA_BITS(DATA_BITS)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .rd_req  (lsu.consumer_read_valid),
      .rd_addr (lsu.consumer_read_address),
      .wr_req  (lsu.consumer_write_valid),
      .wr_addr (lsu.consumer_write_address),
      .wr_data (lsu.consumer_write_data),
      .avail   (av),
      .grant   (gnt),
      .done    (dn),
      .mem_rv  (mem.mem_read_valid[c]),
      .mem_ra  (mem.mem_read_address[c]),
      .mem_rr  (mem.mem_read_ready[c]),
      .mem_rd  (mem.mem_read_data[c]),
      .mem_wv  (mem.mem_write_valid[c]),
      .mem_wa  (mem.mem_write_address[c]),
      .mem_wd  (mem.mem_write_data[c]),
      .mem_wr  (mem.mem_write_ready[c]),
      .idx     (ch_idx[c]),
      .rd_ready(ch_rr[c]),
      .wr_ready(ch_wr[c]),
      .rd_data (ch_rd[c])
    );
  end

  assign granted = ~claim
                 & ~(g_ch[M-1].av & ~g_ch[M-1].gnt);
  assign freed   = g_ch[M-1].dn_acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) claim <= '0;
    else        claim <= (claim | granted) & ~freed;
  end

  // A consumer is owned by at most one channel, so OR-ing is safe.
  always_comb begin
    rr = '0;
    wr = '0;
    rd = '0;
    for (int c = 0; c < M; c++) begin
      if (ch_rr[c]) begin
        rr[ch_idx[c]] = 1'b1;
        rd[ch_idx[c]] = ch_rd[c];
      end
      if (ch_wr[c]) wr[ch_idx[c]] = 1'b1;
    end
  end

  assign lsu.consumer_read_ready  = rr;
  assign lsu.consumer_read_data   = rd;
  assign lsu.consumer_write_ready = wr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: 1-channel and 2-channel builds.
// Memory model answers addr ^ 8'hB5 after a programmable latency.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_arb_lsu_if #(.N(4), .AW(8), .DW(8)) l1 ();
  mem_arb_mem_if #(.M(1), .AW(8), .DW(8)) m1 ();
  mem_arb_lsu_if #(.N(4), .AW(8), .DW(8)) l2 ();
  mem_arb_mem_if #(.M(2), .AW(8), .DW(8)) m2 ();

  mem_arbiter #(.NUM_CHANNELS(1)) dut1 (
    .clk(clk), .reset(reset), .lsu(l1), .mem(m1)
  );
  mem_arbiter #(.NUM_CHANNELS(2)) dut2 (
    .clk(clk), .reset(reset), .lsu(l2), .mem(m2)
  );

  typedef struct {
    int         who;
    logic [7:0] data;
  } rd_exp_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_exp_t;

  rd_exp_t rq[$];
  wr_exp_t wq[$];
  int errs = 0;
  int checks = 0;
  int rlat = 3;

  function automatic logic [7:0] f(logic [7:0] a);
    return a ^ 8'hB5;
  endfunction

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // memory model for the single-channel build
  initial begin
    int cnt;
    logic wv_prev;
    wr_exp_t w;
    cnt = 0;
    wv_prev = 1'b0;
    m1.mem_read_ready  = '0;
    m1.mem_read_data   = '0;
    m1.mem_write_ready = '0;
    forever begin
      @(negedge clk);
      m1.mem_read_ready  = '0;
      m1.mem_write_ready = '0;
      if (m1.mem_write_valid[0] && !wv_prev) begin
        if (wq.size() == 0) chk("wq_underflow", 0, 1);
        else begin
          w = wq.pop_front();
          chk("wr_addr", m1.mem_write_address[0], w.addr);
          chk("wr_data", m1.mem_write_data[0], w.data);
        end
      end
      wv_prev = m1.mem_write_valid[0];
      if (!reset) cnt = 0;
      else if (m1.mem_read_valid[0] || m1.mem_write_valid[0]) begin
        cnt++;
        if (cnt >= rlat) begin
          cnt = 0;
          if (m1.mem_read_valid[0]) begin
            m1.mem_read_ready = 1'b1;
            m1.mem_read_data[0] = f(m1.mem_read_address[0]);
          end else m1.mem_write_ready = 1'b1;
        end
      end else cnt = 0;
    end
  end

  // read-ready rising edges pop the scoreboard
  initial begin
    logic [3:0] prev;
    rd_exp_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (reset && l1.consumer_read_ready[i] && !prev[i]) begin
          if (rq.size() == 0) chk("rq_underflow", i, 99);
          else begin
            e = rq.pop_front();
            chk("rd_who", i, e.who);
            chk("rd_data", l1.consumer_read_data[i], e.data);
          end
        end
      end
      prev = l1.consumer_read_ready;
    end
  end

  task automatic lsu_rd(int i, logic [7:0] a, int hold,
                        int exp_lat);
    int cyc;
    cyc = 0;
    l1.consumer_read_address[i] = a;
    l1.consumer_read_valid[i] = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
    end while (!l1.consumer_read_ready[i] && cyc < 200);
    chk("rd_seen", l1.consumer_read_ready[i], 1);
    if (exp_lat > 0) chk("rd_lat", cyc, exp_lat);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_rdy", l1.consumer_read_ready[i], 1);
      chk("hold_nogrant", m1.mem_read_valid, 0);
    end
    l1.consumer_read_valid[i] = 1'b0;
    @(negedge clk);
    chk("rd_drop", l1.consumer_read_ready[i], 0);
  endtask

  task automatic lsu_wr(int i, logic [7:0] a, logic [7:0] d,
                        int exp_lat);
    int cyc;
    cyc = 0;
    l1.consumer_write_address[i] = a;
    l1.consumer_write_data[i] = d;
    l1.consumer_write_valid[i] = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
    end while (!l1.consumer_write_ready[i] && cyc < 200);
    chk("wr_seen", l1.consumer_write_ready[i], 1);
    chk("wr_lat", cyc, exp_lat);
    l1.consumer_write_valid[i] = 1'b0;
    @(negedge clk);
    chk("wr_drop", l1.consumer_write_ready[i], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    l1.consumer_read_valid     = '0;
    l1.consumer_read_address   = '0;
    l1.consumer_write_valid    = '0;
    l1.consumer_write_address  = '0;
    l1.consumer_write_data     = '0;
    l2.consumer_read_valid     = '0;
    l2.consumer_read_address   = '0;
    l2.consumer_write_valid    = '0;
    l2.consumer_write_address  = '0;
    l2.consumer_write_data     = '0;
    m2.mem_read_ready          = '0;
    m2.mem_read_data           = '0;
    m2.mem_write_ready         = '0;

    #1;
    chk("rst_mem1", {m1.mem_read_valid, m1.mem_read_address,
        m1.mem_write_valid, m1.mem_write_address,
        m1.mem_write_data}, 0);
    chk("rst_lsu1", {l1.consumer_read_ready,
        l1.consumer_read_data, l1.consumer_write_ready}, 0);
    chk("rst_mem2", {m2.mem_read_valid, m2.mem_write_valid}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // reset while waiting on memory
    rlat = 50;
    l1.consumer_read_address[0] = 8'h55;
    l1.consumer_read_valid[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_busy", m1.mem_read_valid, 1);
    reset = 1'b0;
    #1;
    chk("mid_mem", {m1.mem_read_valid, m1.mem_read_address}, 0);
    chk("mid_lsu", {l1.consumer_read_ready,
        l1.consumer_read_data}, 0);
    l1.consumer_read_valid[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    rlat = 3;
    @(negedge clk);

    // single read, memory ready three cycles after the strobe
    rq.push_back('{2, 8'hA5});
    lsu_rd(2, 8'h10, 0, 4);

    // single write
    wq.push_back('{8'h20, 8'h3C});
    lsu_wr(1, 8'h20, 8'h3C, 4);

    // requester keeps valid high well after ready
    rq.push_back('{3, f(8'h77)});
    lsu_rd(3, 8'h77, 5, 4);

    // four-way contention, consumer0 asks again immediately
    rlat = 1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    rq.push_back('{0, f(8'h40)});
    rq.push_back('{1, f(8'h41)});
    rq.push_back('{2, f(8'h42)});
    rq.push_back('{3, f(8'h43)});
    rq.push_back('{0, f(8'h44)});
`else
    rq.push_back('{0, f(8'h40)});
    rq.push_back('{0, f(8'h44)});
    rq.push_back('{1, f(8'h41)});
    rq.push_back('{2, f(8'h42)});
    rq.push_back('{3, f(8'h43)});
`endif
    fork
      begin
        lsu_rd(0, 8'h40, 0, 0);
        lsu_rd(0, 8'h44, 0, 0);
      end
      lsu_rd(1, 8'h41, 0, 0);
      lsu_rd(2, 8'h42, 0, 0);
      lsu_rd(3, 8'h43, 0, 0);
    join
    rlat = 3;

    // two channels grab consumers 1 and 3 in one cycle
    l2.consumer_read_address[1] = 8'h31;
    l2.consumer_read_address[3] = 8'h33;
    l2.consumer_read_valid = 4'b1010;
    @(negedge clk);
    chk("dual_v", m2.mem_read_valid, 2'b11);
    chk("dual_a0", m2.mem_read_address[0], 8'h31);
    chk("dual_a1", m2.mem_read_address[1], 8'h33);
    m2.mem_read_data[0] = 8'hD1;
    m2.mem_read_data[1] = 8'hD3;
    m2.mem_read_ready = 2'b11;
    @(negedge clk);
    m2.mem_read_ready = 2'b00;
    chk("dual_mv", m2.mem_read_valid, 2'b00);
    chk("dual_rr", l2.consumer_read_ready, 4'b1010);
    chk("dual_d1", l2.consumer_read_data[1], 8'hD1);
    chk("dual_d3", l2.consumer_read_data[3], 8'hD3);
    @(negedge clk);
    chk("dual_nogrant", m2.mem_read_valid, 2'b00);
    l2.consumer_read_valid = 4'b0000;
    @(negedge clk);
    chk("dual_drop", l2.consumer_read_ready, 4'b0000);

    repeat (2) @(negedge clk);
    chk("rq_left", rq.size(), 0);
    chk("wq_left", wq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
